// File: rtl/vx_mem_line_responder_pkg.sv
// Shared types and constants for the line-granular memory responder.
package vx_mem_line_responder_pkg;

    localparam int unsigned PERF_CNT_W      = 44;
    localparam int unsigned MEM_RSP_LAT_MAX = 16;

    // Performance counter bundle (present only with MEM_RESPONDER_PERF_EN)
    typedef struct packed {
        logic [PERF_CNT_W-1:0] reads;
        logic [PERF_CNT_W-1:0] writes;
        logic [PERF_CNT_W-1:0] stalls;
    } mem_responder_perf_t;

    // Saturating increment for the perf counters
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vx_mem_line_responder_fifo.sv
// Response queue: power-of-two depth circular buffer, head presented on data_out.
module vx_mem_line_responder_fifo #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] store [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign data_out = store[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= data_in;
    end

    // Credit accounting upstream makes an overflowing push unreachable
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && full));
    end

endmodule

// File: rtl/vx_mem_line_responder.sv
// Line-granular memory slave: byte-enabled line array, fixed-latency read
// pipeline, credit-limited response queue. Optional perf counters are built
// when MEM_RESPONDER_PERF_EN is defined.
module vx_mem_line_responder
    import vx_mem_line_responder_pkg::*;
#(
    parameter int unsigned LINE_SIZE  = 64,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned RSQ_SIZE   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    input  logic                   mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic [LINE_SIZE-1:0]   mem_req_byteen,
    input  logic [8*LINE_SIZE-1:0] mem_req_data,
    input  logic [TAG_WIDTH-1:0]   mem_req_tag,
    output logic                   mem_req_ready,
    output logic                   mem_rsp_valid,
    output logic [8*LINE_SIZE-1:0] mem_rsp_data,
    output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
    input  logic                   mem_rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]  perf_reads,
    output logic [PERF_CNT_W-1:0]  perf_writes,
    output logic [PERF_CNT_W-1:0]  perf_stalls
`endif
);

    localparam int unsigned DATAW   = 8 * LINE_SIZE;
    localparam int unsigned ENTW    = TAG_WIDTH + DATAW;
    localparam int unsigned LINES   = 1 << DEPTH_LOG2;
    localparam int unsigned CREDW   = $clog2(RSQ_SIZE + 1);
    localparam int unsigned LAT_EFF = (LATENCY > MEM_RSP_LAT_MAX) ? MEM_RSP_LAT_MAX : LATENCY;
    // The accept cycle itself counts as the first latency stage
    localparam int unsigned PIPE_D  = (LAT_EFF > 1) ? LAT_EFF - 1 : 1;

    logic                  req_fire;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  rsp_fire;
    logic [CREDW-1:0]      credit_cnt;
    logic [DEPTH_LOG2-1:0] line_idx;
    logic                  addr_unused;
    logic [DATAW-1:0]      line_array [LINES];
    logic [DATAW-1:0]      rd_line;
    logic                  pipe_valid [PIPE_D];
    logic [ENTW-1:0]       pipe_ent   [PIPE_D];
    logic                  push;
    logic [ENTW-1:0]       push_ent;
    logic [ENTW-1:0]       q_out;
    logic                  q_empty;
    logic                  q_full;

    assign mem_req_ready = !reset && (credit_cnt < CREDW'(RSQ_SIZE));
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rd_fire       = req_fire && !mem_req_rw;
    assign wr_fire       = req_fire && mem_req_rw;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

    // Upper address bits alias onto the same lines
    assign line_idx    = mem_req_addr[DEPTH_LOG2-1:0];
    assign addr_unused = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
    assign rd_line     = line_array[line_idx];

    // Byte-enabled line writes; array contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < LINE_SIZE; b++) begin
                if (mem_req_byteen[b]) line_array[line_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
            end
        end
    end

    // Read pipeline valid bits; reset drops in-flight reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_D; i++) pipe_valid[i] <= 1'b0;
        end else begin
            pipe_valid[0] <= rd_fire;
            for (int i = 1; i < PIPE_D; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    // Read pipeline payload (tag + line data)
    always_ff @(posedge clk) begin
        pipe_ent[0] <= {mem_req_tag, rd_line};
        for (int i = 1; i < PIPE_D; i++) pipe_ent[i] <= pipe_ent[i-1];
    end

    if (LAT_EFF == 1) begin : g_direct
        assign push     = rd_fire;
        assign push_ent = {mem_req_tag, rd_line};
    end else begin : g_piped
        assign push     = pipe_valid[PIPE_D-1];
        assign push_ent = pipe_ent[PIPE_D-1];
    end

    // Outstanding-read credits cover both the pipeline and the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_cnt <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   credit_cnt <= credit_cnt + CREDW'(1);
                2'b01:   credit_cnt <= credit_cnt - CREDW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    vx_mem_line_responder_fifo #(
        .DATAW (ENTW),
        .DEPTH (RSQ_SIZE)
    ) u_rsp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (rsp_fire),
        .data_in  (push_ent),
        .data_out (q_out),
        .empty    (q_empty),
        .full     (q_full)
    );

    assign mem_rsp_valid               = !q_empty;
    assign {mem_rsp_tag, mem_rsp_data} = q_out;

`ifdef MEM_RESPONDER_PERF_EN
    mem_responder_perf_t perf;

    // Saturating accept/stall counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf <= '0;
        end else begin
            if (rd_fire) perf.reads  <= sat_inc(perf.reads);
            if (wr_fire) perf.writes <= sat_inc(perf.writes);
            if (mem_req_valid && !mem_req_ready) perf.stalls <= sat_inc(perf.stalls);
        end
    end

    assign perf_reads  = perf.reads;
    assign perf_writes = perf.writes;
    assign perf_stalls = perf.stalls;
`endif

endmodule

// File: tb/tb_vx_mem_line_responder.sv
// Bench for vx_mem_line_responder: directed scenarios plus randomized traffic
// against a queue-based reference model. Perf scenario needs MEM_RESPONDER_PERF_EN.
module tb_vx_mem_line_responder;

    localparam int unsigned LS  = 64;
    localparam int unsigned AW  = 26;
    localparam int unsigned DL  = 10;
    localparam int unsigned TW  = 8;
    localparam int unsigned LAT = 4;
    localparam int unsigned RSQ = 4;
    localparam int unsigned DW  = 8 * LS;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [LS-1:0] req_byteen;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready;
`ifdef MEM_RESPONDER_PERF_EN
    logic [43:0]   perf_reads;
    logic [43:0]   perf_writes;
    logic [43:0]   perf_stalls;
`endif

    always #5 clk = ~clk;

    vx_mem_line_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (req_valid),
        .mem_req_rw     (req_rw),
        .mem_req_addr   (req_addr),
        .mem_req_byteen (req_byteen),
        .mem_req_data   (req_data),
        .mem_req_tag    (req_tag),
        .mem_req_ready  (req_ready),
        .mem_rsp_valid  (rsp_valid),
        .mem_rsp_data   (rsp_data),
        .mem_rsp_tag    (rsp_tag),
        .mem_rsp_ready  (rsp_ready)
`ifdef MEM_RESPONDER_PERF_EN
        ,
        .perf_reads     (perf_reads),
        .perf_writes    (perf_writes),
        .perf_stalls    (perf_stalls)
`endif
    );

    // Reference model: every unconsumed read is one queue entry with its due cycle
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } exp_rsp_t;

    exp_rsp_t      exp_q[$];
    logic [DW-1:0] mm [1 << DL];
    int            cyc;
    int            checks;
    int            passes;

    function automatic bit m_ready();
        return !reset && (exp_q.size() < RSQ);
    endfunction

    function automatic bit m_valid();
        return (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_req(input bit v, input bit rw, input logic [AW-1:0] a,
                           input logic [LS-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_valid  = v;
        req_rw     = rw;
        req_addr   = a;
        req_byteen = be;
        req_data   = d;
        req_tag    = t;
    endtask

    // One clock: model decides acceptance/consumption from spec rules, then updates
    task automatic advance();
        bit acc;
        bit fire;
        int idx;
        acc  = req_valid && m_ready();
        fire = rsp_ready && m_valid();
        @(posedge clk);
        if (fire) void'(exp_q.pop_front());
        if (acc) begin
            idx = int'(req_addr[DL-1:0]);
            if (req_rw) begin
                for (int b = 0; b < LS; b++) begin
                    if (req_byteen[b]) mm[idx][b*8 +: 8] = req_data[b*8 +: 8];
                end
            end else begin
                exp_q.push_back('{tag: req_tag, data: mm[idx], due: cyc + LAT});
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passes++;
        advance();
        advance();
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready_held got=%b exp=0", req_ready); else passes++;
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL post_reset_rsp_valid got=%b exp=0", rsp_valid); else passes++;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] a5;
        a5 = {64{8'hA5}};
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, AW'(5), '1, a5, '0);
        advance();
        set_req(1'b1, 1'b0, AW'(5), '0, '0, 8'h11);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (rsp_valid !== (k == LAT)) $display("FAIL wr_rd_latency k=%0d got=%b exp=%b", k, rsp_valid, (k == LAT));
            else passes++;
            if (k == LAT) begin
                checks++; if (rsp_tag !== 8'h11) $display("FAIL wr_rd_tag got=%h exp=11", rsp_tag); else passes++;
                checks++; if (rsp_data !== a5) $display("FAIL wr_rd_data got=%h exp=%h", rsp_data, a5); else passes++;
            end
            advance();
        end
    endtask

    task automatic test_partial();
        logic [DW-1:0] exp_line;
        bit            got;
        exp_line        = '0;
        exp_line[31:0]  = 32'hFFFF_FFFF;
        got             = 1'b0;
        rsp_ready       = 1'b1;
        set_req(1'b1, 1'b1, AW'(9), '1, '0, '0);
        advance();
        set_req(1'b1, 1'b1, AW'(9), LS'(4'hF), '1, '0);
        advance();
        set_req(1'b1, 1'b0, AW'(9), '0, '0, 8'h22);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < LAT + 4 && !got; k++) begin
            if (rsp_valid) begin
                got = 1'b1;
                checks++; if (rsp_tag !== 8'h22) $display("FAIL partial_tag got=%h exp=22", rsp_tag); else passes++;
                checks++; if (rsp_data !== exp_line) $display("FAIL partial_data got=%h exp=%h", rsp_data, exp_line); else passes++;
            end
            advance();
        end
        checks++; if (!got) $display("FAIL partial_timeout got=no_response exp=response"); else passes++;
    endtask

    task automatic test_credit();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0, AW'(5), '0, '0, TW'(8'h30 + i));
            checks++;
            if (req_ready !== (i < RSQ)) $display("FAIL credit_ready i=%0d got=%b exp=%b", i, req_ready, (i < RSQ));
            else passes++;
            advance();
        end
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        repeat (LAT + 1) advance();
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== TW'(8'h30 + j))
                $display("FAIL credit_order j=%0d got=%b/%h exp=1/%h", j, rsp_valid, rsp_tag, TW'(8'h30 + j));
            else passes++;
            if (j == 0) begin
                checks++; if (rsp_data !== {64{8'hA5}}) $display("FAIL credit_data got=%h", rsp_data); else passes++;
            end
            advance();
        end
        checks++; if (rsp_valid !== 1'b0) $display("FAIL credit_drained got=%b exp=0", rsp_valid); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL credit_reready got=%b exp=1", req_ready); else passes++;
    endtask

    task automatic test_simul();
        logic [TW-1:0] exp_tags [4];
        int            n;
        exp_tags  = '{8'h42, 8'h43, 8'h45, 8'h46};
        n         = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, AW'(9), '0, '0, TW'(8'h40 + i));
            advance();
        end
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        repeat (LAT) advance();
        set_req(1'b1, 1'b0, AW'(9), '0, '0, 8'h44);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL simul_full_ready got=%b exp=0", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'h40) $display("FAIL simul_fire0 got=%b/%h exp=1/40", rsp_valid, rsp_tag); else passes++;
        advance();
        set_req(1'b1, 1'b0, AW'(9), '0, '0, 8'h45);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL simul_ready3 got=%b exp=1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'h41) $display("FAIL simul_fire1 got=%b/%h exp=1/41", rsp_valid, rsp_tag); else passes++;
        advance();
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, AW'(9), '0, '0, 8'h46);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL simul_still3 got=%b exp=1", req_ready); else passes++;
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL simul_now4 got=%b exp=0", req_ready); else passes++;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                checks++;
                if (n >= 4) $display("FAIL simul_extra got=%h exp=none", rsp_tag);
                else if (rsp_tag !== exp_tags[n]) $display("FAIL simul_drain n=%0d got=%h exp=%h", n, rsp_tag, exp_tags[n]);
                else passes++;
                n++;
            end
            advance();
        end
        checks++; if (n != 4) $display("FAIL simul_count got=%0d exp=4", n); else passes++;
    endtask

    task automatic test_reset_mid();
        int stale;
        stale     = 0;
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, AW'(5), '0, '0, 8'h50);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        repeat (LAT - 1) advance();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b exp=1", rsp_valid); else passes++;
        set_req(1'b1, 1'b0, AW'(5), '0, '0, 8'h51);
        advance();
        set_req(1'b1, 1'b0, AW'(5), '0, '0, 8'h52);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", rsp_valid); else passes++;
        exp_q.delete();
        advance();
        advance();
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_release got=%b exp=1", req_ready); else passes++;
        rsp_ready = 1'b1;
        repeat (LAT + 4) begin
            if (rsp_valid) stale++;
            advance();
        end
        checks++; if (stale != 0) $display("FAIL rstmid_stale got=%0d exp=0", stale); else passes++;
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n < 8) set_req(1'b1, 1'b1, AW'(16 + n), '1, rand_line(), '0);
            else if (n < 20) set_req(1'b1, 1'b0, AW'(16 + (n % 8)), '0, '0, TW'(n));
            else set_req(1'b0, 1'b0, '0, '0, '0, '0);
            checks++;
            if (req_ready !== m_ready()) $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, req_ready, m_ready());
            else passes++;
            checks++;
            if (rsp_valid !== m_valid()) $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, rsp_valid, m_valid());
            else passes++;
            if (m_valid()) begin
                checks++;
                if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data)
                    $display("FAIL b2b_rsp n=%0d got=%h/%h exp=%h/%h", n, rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int            idx;
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 1'b1, AW'(i), '1, rand_line(), '0);
            advance();
        end
        for (int n = 0; n < 320; n++) begin
            if (n < 300) begin
                idx = $urandom_range(0, 15);
                a = AW'($urandom);
                a[DL-1:0] = DL'(idx);
                set_req($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
                        {$urandom, $urandom}, rand_line(), TW'($urandom));
                rsp_ready = ($urandom_range(0, 9) < 7);
            end else begin
                set_req(1'b0, 1'b0, '0, '0, '0, '0);
                rsp_ready = 1'b1;
            end
            checks++;
            if (req_ready !== m_ready()) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, m_ready());
            else passes++;
            checks++;
            if (rsp_valid !== m_valid()) $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rsp_valid, m_valid());
            else passes++;
            if (m_valid()) begin
                checks++;
                if (rsp_tag !== exp_q[0].tag || rsp_data !== exp_q[0].data)
                    $display("FAIL rnd_rsp n=%0d got=%h/%h exp=%h/%h", n, rsp_tag, rsp_data, exp_q[0].tag, exp_q[0].data);
                else passes++;
            end
            advance();
        end
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rnd_drained got=%b exp=0", rsp_valid); else passes++;
    endtask

`ifdef MEM_RESPONDER_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        rsp_ready = 1'b0;
        advance();
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (perf_reads !== 44'd0 || perf_writes !== 44'd0 || perf_stalls !== 44'd0)
            $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", perf_reads, perf_writes, perf_stalls);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, 1'b1, AW'(3), '1, rand_line(), '0);
            advance();
        end
        for (int i = 0; i < 9; i++) begin
            set_req(1'b1, 1'b0, AW'(3), '0, '0, TW'(i));
            advance();
        end
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        advance();
        checks++; if (perf_reads !== 44'd4) $display("FAIL perf_reads got=%0d exp=4", perf_reads); else passes++;
        checks++; if (perf_writes !== 44'd2) $display("FAIL perf_writes got=%0d exp=2", perf_writes); else passes++;
        checks++; if (perf_stalls !== 44'd5) $display("FAIL perf_stalls got=%0d exp=5", perf_stalls); else passes++;
        rsp_ready = 1'b1;
        repeat (LAT + RSQ + 2) advance();
    endtask
`endif

    initial begin
        checks    = 0;
        passes    = 0;
        cyc       = 0;
        reset     = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        test_reset();
        test_write_read();
        test_partial();
        test_credit();
        test_simul();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef MEM_RESPONDER_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
